// File: rtl/mux4_1_pkg.sv
// Shared select encodings for the mux4_1 datapath leaf.
// Imported by the mux and anything that drives its select.
package mux4_1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4_1.sv
// Parameterised 4-to-1 mux with optional registered output
// and a registered select-change pulse.
module mux4_1
    import mux4_1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  sel_t             S,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_chg
);

    logic [WIDTH-1:0] sel_d;
    sel_t             s_d;
    sel_t             s_q;
    logic             sel_chg_d;
    logic             sel_chg_q;

    always_comb begin
        sel_d = '0;
        unique case (S)
            SEL_I0: sel_d = i0;
            SEL_I1: sel_d = i1;
            SEL_I2: sel_d = i2;
            SEL_I3: sel_d = i3;
        endcase
    end

    // Pulse compares the live select against last cycle's sample.
    always_comb begin
        s_d       = S;
        sel_chg_d = (S != s_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            s_q       <= SEL_I0;
            sel_chg_q <= 1'b0;
        end else begin
            out_q     <= sel_d;
            s_q       <= s_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign sel_chg = sel_chg_q;

    generate
        if (REG_OUT) begin : g_reg_out
            assign out = out_q;
        end else begin : g_comb_out
            assign out = sel_d;
        end
    endgenerate

endmodule

// File: tb/tb_mux4_1.sv
// Scoreboard bench for mux4_1: combinational, registered and 8-bit variants.
// Stimulus queues expected values; a monitor pops and compares on each strobe.
module tb_mux4_1;

    logic       clk;
    logic       rst_n;
    logic       a0, a1, a2, a3;
    logic [1:0] sa;
    logic [7:0] b0, b1, b2, b3;
    logic [1:0] sb;

    logic       c_out, c_out_q, c_chg;
    logic       r_out, r_out_q, r_chg;
    logic [7:0] w_out, w_out_q;
    logic       w_chg;

    mux4_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n),
        .i0(a0), .i1(a1), .i2(a2), .i3(a3), .S(sa),
        .out(c_out), .out_q(c_out_q), .sel_chg(c_chg)
    );

    mux4_1 #(.WIDTH(1), .REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n),
        .i0(a0), .i1(a1), .i2(a2), .i3(a3), .S(sa),
        .out(r_out), .out_q(r_out_q), .sel_chg(r_chg)
    );

    mux4_1 #(.WIDTH(8), .REG_OUT(1'b0)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .i0(b0), .i1(b1), .i2(b2), .i3(b3), .S(sb),
        .out(w_out), .out_q(w_out_q), .sel_chg(w_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        C_OUT, C_OUTQ, C_CHG, R_OUT, R_OUTQ, R_CHG, W_OUT, W_OUTQ, W_CHG
    } probe_t;

    typedef struct {
        probe_t     id;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_v(input probe_t id, input logic [7:0] e,
                            input string nm);
        exp_t x;
        x.id   = id;
        x.exp  = e;
        x.name = nm;
        q.push_back(x);
    endtask

    function automatic logic [7:0] probe(input probe_t id);
        logic [7:0] v;
        v = 8'h00;
        case (id)
            C_OUT:  v = {7'd0, c_out};
            C_OUTQ: v = {7'd0, c_out_q};
            C_CHG:  v = {7'd0, c_chg};
            R_OUT:  v = {7'd0, r_out};
            R_OUTQ: v = {7'd0, r_out_q};
            R_CHG:  v = {7'd0, r_chg};
            W_OUT:  v = w_out;
            W_OUTQ: v = w_out_q;
            W_CHG:  v = {7'd0, w_chg};
            default: v = 8'hxx;
        endcase
        return v;
    endfunction

    // Monitor: drains everything queued since the last strobe.
    initial begin
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                exp_t x;
                logic [7:0] act;
                x   = q.pop_front();
                act = probe(x.id);
                n_cmp++;
                if (act !== x.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, want %h at t=%0t",
                             x.name, act, x.exp, $time);
                end
            end
        end
    end

    task automatic strobe();
        ->chk_ev;
        #0;
    endtask

    // One registered cycle: change S at negedge, check after posedge.
    task automatic reg_step(input logic [1:0] s, input logic eo,
                            input logic ec, input string nm);
        @(negedge clk);
        sa = s;
        @(posedge clk);
        #1;
        expect_v(R_OUTQ, {7'd0, eo}, {nm, ".out_q"});
        expect_v(R_OUT,  {7'd0, eo}, {nm, ".out"});
        expect_v(R_CHG,  {7'd0, ec}, {nm, ".sel_chg"});
        strobe();
    endtask

    logic [7:0] wexp [4];

    initial begin
        rst_n = 1'b0;
        a0 = 1'b1; a1 = 1'b0; a2 = 1'b0; a3 = 1'b1;
        sa = 2'b00;
        b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00;
        sb = 2'b00;
        wexp[0] = 8'hA5; wexp[1] = 8'h3C;
        wexp[2] = 8'hFF; wexp[3] = 8'h00;

        #1;
        expect_v(C_OUTQ, 8'd0, "rst.c_out_q");
        expect_v(C_CHG,  8'd0, "rst.c_chg");
        expect_v(R_OUTQ, 8'd0, "rst.r_out_q");
        expect_v(R_OUT,  8'd0, "rst.r_out");
        expect_v(R_CHG,  8'd0, "rst.r_chg");
        expect_v(W_OUTQ, 8'd0, "rst.w_out_q");
        expect_v(W_CHG,  8'd0, "rst.w_chg");
        expect_v(C_OUT,  8'd1, "rst.c_out_tracks");
        strobe();

        // Combinational sweep during reset: 1,0,0,1
        for (int k = 0; k < 4; k++) begin
            #4;
            sa = k[1:0];
            #1;
            expect_v(C_OUT, {7'd0, (k == 0 || k == 3)}, "comb.sweep");
            expect_v(R_OUT, 8'd0, "comb.r_out_in_rst");
            strobe();
        end

        sa = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        reg_step(2'b00, 1'b1, 1'b0, "reg.s00");
        reg_step(2'b01, 1'b0, 1'b1, "reg.s01");
        reg_step(2'b10, 1'b0, 1'b1, "reg.s10");
        reg_step(2'b11, 1'b1, 1'b1, "reg.s11");

        // Hold S=10: one pulse on entry, then quiet, then one on exit.
        reg_step(2'b10, 1'b0, 1'b1, "hold.enter");
        reg_step(2'b10, 1'b0, 1'b0, "hold.1");
        reg_step(2'b10, 1'b0, 1'b0, "hold.2");
        reg_step(2'b10, 1'b0, 1'b0, "hold.3");
        reg_step(2'b11, 1'b1, 1'b1, "hold.exit");
        reg_step(2'b11, 1'b1, 1'b0, "hold.after");

        // Async reset mid-cycle with out_q=1 and a pulse pending.
        reg_step(2'b00, 1'b1, 1'b1, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        expect_v(R_OUTQ, 8'd0, "arst.out_q");
        expect_v(R_OUT,  8'd0, "arst.out");
        expect_v(R_CHG,  8'd0, "arst.sel_chg");
        expect_v(C_OUT,  8'd1, "arst.c_out_tracks");
        strobe();
        @(negedge clk);
        rst_n = 1'b1;
        reg_step(2'b11, 1'b1, 1'b1, "post_rst.first");

        // 8-bit sweep
        for (int k = 0; k < 4; k++) begin
            #3;
            sb = k[1:0];
            #1;
            expect_v(W_OUT, wexp[k], "wide.sweep");
            strobe();
        end

        // S=01: only i1 matters
        sa = 2'b01;
        for (int k = 0; k < 6; k++) begin
            #3;
            a1 = k[0];
            a0 = ~k[1];
            a2 = k[1];
            a3 = k[2];
            #1;
            expect_v(C_OUT, {7'd0, k[0]}, "s01.follow_i1");
            strobe();
        end

        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux4_1.md
Name: mux4_1

Overview:
- Parameterised 4-to-1 multiplexer: a 2-bit select `S` chooses one of four data inputs.
- Provides a zero-latency combinational output and an optional registered copy.
- Provides a select-change pulse for downstream monitoring.
- Used as a leaf datapath element; the combinational `out` path has no clock dependency.

Parameters:
- WIDTH, 1, bit width of each data input and of both data outputs.
- REG_OUT, 0, 0 = `out` is combinational; 1 = `out` equals `out_q` (one-cycle latency).

Ports:
- clk  input  1  single clock for the registered paths.
- rst_n  input  1  reset for all flops; asynchronous, active-low.
- i0  input  WIDTH  data input, selected when S=2'b00.
- i1  input  WIDTH  data input, selected when S=2'b01.
- i2  input  WIDTH  data input, selected when S=2'b10.
- i3  input  WIDTH  data input, selected when S=2'b11.
- S  input  2  select.
- out  output  WIDTH  selected data (combinational when REG_OUT=0).
- out_q  output  WIDTH  selected data registered on rising clk.
- sel_chg  output  1  one-cycle pulse when registered S differs from the previous registered S.

Behaviour:
- Combinational select: `sel_d = (S==0)?i0 : (S==1)?i1 : (S==2)?i2 : i3`. This is a full case with no priority and no latch.
- REG_OUT=0: `out = sel_d`.
  - Changes on `S` or any `iN` appear on `out` in the same delta/time step.
  - No clock or reset involvement.
- REG_OUT=1: `out = out_q`.
- `out_q`: on posedge clk, `out_q <= sel_d`.
- `S_q`: on posedge clk, `S_q <= S`. `S_q` is an internal register.
- `sel_chg`: registered. On posedge clk, `sel_chg <= (S != S_q)`. It asserts for exactly one cycle per change.
- Reset (`rst_n` low, asynchronous assert):
  - `out_q = 0`, `S_q = 2'b00`, `sel_chg = 0`, taking effect immediately without waiting for clk.
  - With REG_OUT=0, `out` still tracks inputs during reset.
- Reset deassertion is synchronised by the integrator. The first rising edge after deassert samples normally.
- Reset asserted mid-operation clears the registered outputs at once. Any pending change pulse is lost.
- Boundary conditions:
  - All four select codes are legal; there is no error output.
  - S held constant means `sel_chg` stays 0.
  - S toggling every cycle means `sel_chg` stays 1 continuously.
  - A first sample of S≠00 after reset produces a `sel_chg` pulse.
- Width rules: all data paths are exactly WIDTH bits with no extension or truncation.

Decomposition:
- Shared package `mux4_1_pkg`:
  - Select encodings SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11.
  - Typedef `sel_t` (logic [1:0]).
- Single module; no sub-module is warranted.
- The combinational select function and the register block live in the same file.

Test Plan:
- Drive i0=1, i1=0, i2=0, i3=1 (WIDTH=1, REG_OUT=0). Step S=00,01,10,11 every 5 time units. Required `out` = 1,0,0,1 in the same time step as each S change.
- Same inputs with REG_OUT=1 and clk running:
  - `out`/`out_q` updates on the first rising edge after each S change.
  - Both are 0 while rst_n=0.
- Assert rst_n=0 asynchronously mid-cycle with out_q=1 -> `out_q` and `sel_chg` go to 0 immediately, before the next clk edge.
- Hold S=10 for 4 cycles then switch to 11 -> `sel_chg` = 0 during the hold, then 1 for exactly one cycle.
- WIDTH=8 with i0=8'hA5, i1=8'h3C, i2=8'hFF, i3=8'h00. Sweep S -> `out` = A5,3C,FF,00, with no bit loss.
- Hold S=01 and toggle i1 between 0 and 1 each step -> `out` follows i1. Changes on i0, i2 and i3 have no effect.
